// File: rtl/tc_result_drain.sv
// Buffers DEPTH whole 4x4 fp16 tiles; a tile written at edge N presents row 0 from N+1, one 64-bit row per handshake.
// Backpressure: rows hold while row_ready=0; a tile arriving while full with no same-cycle pop is dropped and counted.
module tc_result_drain #(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [0:3][0:3][15:0]      d,
  output logic                       row_valid,
  input  logic                       row_ready,
  output logic [63:0]                row_data,
  output logic [1:0]                 row_idx,
  output logic                       row_last,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       overflow,
  output logic [7:0]                 drop_count
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [0:3][0:3][15:0] tile_t;

  tile_t           mem [DEPTH];
  tile_t           head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            full;
  logic            hs;
  logic            pop;
  logic            push;
  logic            drop;

  assign full      = (occupancy == (AW+1)'(DEPTH));
  assign row_valid = (occupancy != '0);
  assign hs        = row_valid & row_ready;
  assign pop       = hs & (row_idx == 2'd3);
  // A final-row pop frees the head slot this same edge, so a full buffer can still accept.
  assign push      = in_valid & (~full | pop);
  assign drop      = in_valid & full & ~pop;

  assign head      = mem[rd_ptr];
  assign row_data  = {head[row_idx][3], head[row_idx][2], head[row_idx][1], head[row_idx][0]};
  assign row_last  = (row_idx == 2'd3) & ~rst;

  // Storage is left unreset; row_valid keeps stale entries from ever being presented.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr] <= d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      row_idx    <= 2'd0;
      occupancy  <= '0;
      overflow   <= 1'b0;
      drop_count <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (hs) begin
        row_idx <= row_idx + 2'd1;
      end
      if (push && !pop) begin
        occupancy <= occupancy + 1'b1;
      end else if (pop && !push) begin
        occupancy <= occupancy - 1'b1;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hff) begin
          drop_count <= drop_count + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_tc_result_drain.sv
// Bench for tc_result_drain: two instances (DEPTH 2 and 4) share stimulus; a reference model feeds row queues
// that a negedge monitor drains on each handshake, alongside directed hand-computed checks on the DEPTH=2 unit.
module tb_tc_result_drain;

  typedef logic [0:3][0:3][15:0] tile_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  tile_t       d;
  logic        row_ready;

  logic        rv    [2];
  logic [63:0] rdat  [2];
  logic [1:0]  ridx  [2];
  logic        rlast [2];
  logic [2:0]  occ   [2];
  logic        ovf   [2];
  logic [7:0]  drops [2];
  logic [1:0]  occ_a;
  logic [2:0]  occ_b;

  assign occ[0] = {1'b0, occ_a};
  assign occ[1] = occ_b;

  tc_result_drain #(.DEPTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d(d),
    .row_valid(rv[0]), .row_ready(row_ready), .row_data(rdat[0]), .row_idx(ridx[0]),
    .row_last(rlast[0]), .occupancy(occ_a), .overflow(ovf[0]), .drop_count(drops[0])
  );

  tc_result_drain #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .d(d),
    .row_valid(rv[1]), .row_ready(row_ready), .row_data(rdat[1]), .row_idx(ridx[1]),
    .row_last(rlast[1]), .occupancy(occ_b), .overflow(ovf[1]), .drop_count(drops[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int dep(input int k);
    return (k == 0) ? 2 : 4;
  endfunction

  function automatic tile_t make_tile(input logic [15:0] base);
    tile_t t;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        t[r][c] = base + 16'(r * 256) + 16'(c);
      end
    end
    return t;
  endfunction

  // Reference model: expected rows as {row index, row data}
  logic [65:0] q0 [$];
  logic [65:0] q1 [$];
  int          m_occ   [2];
  int          m_hidx  [2];
  int          m_drops [2];
  logic        m_ovf   [2];
  int          rows_seen [2];
  logic        mon_en;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      logic        hs, pop, push;
      logic [65:0] e;
      if (rst) begin
        m_occ[k]   = 0;
        m_hidx[k]  = 0;
        m_drops[k] = 0;
        m_ovf[k]   = 1'b0;
        if (k == 0) q0.delete(); else q1.delete();
      end else begin
        hs   = (m_occ[k] != 0) && row_ready;
        pop  = hs && (m_hidx[k] == 3);
        push = in_valid && ((m_occ[k] < dep(k)) || pop);
        if (hs) m_hidx[k] = (m_hidx[k] + 1) % 4;
        if (push) begin
          for (int r = 0; r < 4; r++) begin
            e = {2'(r), d[r][3], d[r][2], d[r][1], d[r][0]};
            if (k == 0) q0.push_back(e); else q1.push_back(e);
          end
        end
        m_occ[k] = m_occ[k] + (push ? 1 : 0) - (pop ? 1 : 0);
        if (in_valid && !push) begin
          m_ovf[k] = 1'b1;
          if (m_drops[k] < 255) m_drops[k]++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (mon_en && !rst) begin
      for (int k = 0; k < 2; k++) begin
        logic [65:0] e;
        logic        empty;
        chk($sformatf("d%0d_row_valid", dep(k)), 64'(rv[k]), 64'(m_occ[k] != 0));
        chk($sformatf("d%0d_occupancy", dep(k)), 64'(occ[k]), 64'(m_occ[k]));
        chk($sformatf("d%0d_overflow", dep(k)), 64'(ovf[k]), 64'(m_ovf[k]));
        chk($sformatf("d%0d_drop_count", dep(k)), 64'(drops[k]), 64'(m_drops[k]));
        if (rv[k] && row_ready) begin
          empty = (k == 0) ? (q0.size() == 0) : (q1.size() == 0);
          if (empty) begin
            chk($sformatf("d%0d_unexpected_row", dep(k)), 64'(1), 64'(0));
          end else begin
            if (k == 0) e = q0.pop_front(); else e = q1.pop_front();
            rows_seen[k]++;
            chk($sformatf("d%0d_row_data", dep(k)), rdat[k], e[63:0]);
            chk($sformatf("d%0d_row_idx", dep(k)), 64'(ridx[k]), 64'(e[65:64]));
            chk($sformatf("d%0d_row_last", dep(k)), 64'(rlast[k]), 64'(e[65:64] == 2'd3));
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] base);
    in_valid = 1'b1;
    d        = make_tile(base);
    step();
    in_valid = 1'b0;
  endtask

  int base_rows;

  initial begin
    mon_en       = 1'b0;
    rows_seen[0] = 0;
    rows_seen[1] = 0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    d         = make_tile(16'hf000);
    row_ready = 1'b0;

    // Reset state, with in_valid held high during reset
    step();
    step();
    @(negedge clk);
    chk("rst_row_valid", 64'(rv[0]), 64'(0));
    chk("rst_row_idx", 64'(ridx[0]), 64'(0));
    chk("rst_row_last", 64'(rlast[0]), 64'(0));
    chk("rst_occupancy", 64'(occ[0]), 64'(0));
    chk("rst_overflow", 64'(ovf[0]), 64'(0));
    chk("rst_drop_count", 64'(drops[0]), 64'(0));
    step();
    rst      = 1'b0;
    in_valid = 1'b0;
    mon_en   = 1'b1;

    // Single tile, row_ready held high
    row_ready = 1'b1;
    send(16'h0000);
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      chk($sformatf("single_row%0d_col0", r), 64'(rdat[0][15:0]), 64'(16'(r * 256)));
      chk($sformatf("single_row%0d_idx", r), 64'(ridx[0]), 64'(r));
      chk($sformatf("single_row%0d_last", r), 64'(rlast[0]), 64'(r == 3));
    end
    @(negedge clk);
    chk("single_after_valid", 64'(rv[0]), 64'(0));
    chk("single_after_occ", 64'(occ[0]), 64'(0));
    step();

    // Backpressure: row 0 held for 5 cycles
    row_ready = 1'b0;
    send(16'h1000);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_data", rdat[0], 64'h1003_1002_1001_1000);
      chk("bp_hold_idx", 64'(ridx[0]), 64'(0));
    end
    step();
    row_ready = 1'b1;
    repeat (6) step();

    // Overflow with three tiles into DEPTH=2
    row_ready = 1'b0;
    send(16'h2000);
    send(16'h3000);
    send(16'h4000);
    @(negedge clk);
    chk("ovf_occupancy", 64'(occ[0]), 64'(2));
    chk("ovf_flag", 64'(ovf[0]), 64'(1));
    chk("ovf_drop_count", 64'(drops[0]), 64'(1));
    base_rows = rows_seen[0];
    step();
    row_ready = 1'b1;
    repeat (10) step();
    chk("ovf_rows_drained", 64'(rows_seen[0] - base_rows), 64'(8));
    chk("ovf_drained_occ", 64'(occ[0]), 64'(0));

    // Push coincident with final-row pop while full
    row_ready = 1'b0;
    send(16'h5000);
    send(16'h6000);
    row_ready = 1'b1;
    repeat (3) step();
    send(16'h7000);
    @(negedge clk);
    chk("fullpp_occupancy", 64'(occ[0]), 64'(2));
    chk("fullpp_drop_count", 64'(drops[0]), 64'(1));
    chk("fullpp_next_head", rdat[0], 64'h6003_6002_6001_6000);
    step();
    repeat (10) step();

    // Reset mid-drain with two tiles buffered
    row_ready = 1'b0;
    send(16'h8000);
    send(16'h9000);
    row_ready = 1'b1;
    step();
    step();
    row_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_row_valid", 64'(rv[0]), 64'(0));
    chk("midrst_occupancy", 64'(occ[0]), 64'(0));
    chk("midrst_overflow", 64'(ovf[0]), 64'(0));
    chk("midrst_drop_count", 64'(drops[0]), 64'(0));
    step();
    row_ready = 1'b1;
    send(16'ha000);
    @(negedge clk);
    chk("midrst_new_idx", 64'(ridx[0]), 64'(0));
    chk("midrst_new_row0", rdat[0], 64'ha003_a002_a001_a000);
    step();
    repeat (6) step();

    // Random traffic, alternating low/high drain pressure
    for (int i = 0; i < 10000; i++) begin
      row_ready = ($urandom_range(0, 99) < (((i / 500) % 2 == 1) ? 80 : 20));
      in_valid  = ($urandom_range(0, 99) < 30);
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          d[r][c] = 16'($urandom);
        end
      end
      step();
    end
    in_valid  = 1'b0;
    row_ready = 1'b1;
    repeat (40) step();
    chk("final_q0_empty", 64'(q0.size()), 64'(0));
    chk("final_q1_empty", 64'(q1.size()), 64'(0));
    chk("final_d4_ovf_vs_drops", 64'(ovf[1]), 64'(drops[1] != 8'd0));
    chk("final_d4_drops_model", 64'(drops[1]), 64'(m_drops[1]));

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
